// File: rtl/stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stage_sequencer_pkg
// Shared definitions for the multi-cycle stage controller and every per-stage
// control block that decodes the shared `stage` bus.
//   NUM_STAGES / STAGE_W : number of stages and width of the stage bus
//   STAGE_*              : stage encodings, FETCH=0 ... WRITEBACK=4
//   seq_state_e          : controller FSM state encodings
// -----------------------------------------------------------------------------
`ifndef NUM_STAGES
`define NUM_STAGES 5
`endif

package stage_sequencer_pkg;

    localparam int NUM_STAGES = `NUM_STAGES;
    localparam int STAGE_W    = $clog2(NUM_STAGES);

    localparam logic [STAGE_W-1:0] STAGE_INSTR_FETCH = STAGE_W'(0);
    localparam logic [STAGE_W-1:0] STAGE_DECODE      = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] STAGE_EXECUTE     = STAGE_W'(2);
    localparam logic [STAGE_W-1:0] STAGE_MEM         = STAGE_W'(3);
    localparam logic [STAGE_W-1:0] STAGE_WRITEBACK   = STAGE_W'(4);

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_HALTED = 2'd2,
        SEQ_FAULT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// -----------------------------------------------------------------------------
// stage_wait_timer
// Counts memory wait cycles for the current FETCH/MEM stage and flags when the
// allowed budget has been used up.
//   clk, rst_n : clock, asynchronous active-low reset
//   count      : this cycle is a wait cycle (request high, ready low)
//   clear      : stage advanced or controller not running; restart from 0
//   expired    : MAX_WAIT wait cycles have already been counted
// -----------------------------------------------------------------------------
module stage_wait_timer #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count,
    input  logic clear,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    assign expired = (cnt_q == LIMIT);

    // Saturates at LIMIT so the counter never wraps while the FSM decides
    // between "ready just arrived" and "timeout".
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Multi-cycle stage controller for the non-pipelined core. Walks the shared
// `stage` bus FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK, stretching FETCH
// and MEM while memory is busy, faulting on a memory timeout and parking the
// core on a HALT instruction.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin/resume from IDLE or HALTED (ignored elsewhere)
//   imem_ready            instruction memory returned data this cycle
//   mem_op, halt_instr    decode results, valid from DECODE onward
//   dmem_ready            data memory completed access this cycle
//   stage                 current stage encoding
//   imem_req, dmem_req    memory requests
//   retire                one-cycle pulse in WRITEBACK
//   halted, fault         parked after HALT / sticky memory timeout
//   perf_retired/stalls   performance counters
//
// Optional feature: define SEQ_PERF_COUNTERS_EN to build the performance
// counters; otherwise both perf ports are tied to 0.
//
// Handshake: a request (imem_req/dmem_req) is held high, with the stage
// frozen, until the matching ready is seen high in the same cycle; the stage
// advances on that edge. A ready without a request is ignored.
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               imem_ready,
    input  logic               mem_op,
    input  logic               dmem_ready,
    input  logic               halt_instr,
    output logic [STAGE_W-1:0] stage,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               retire,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        perf_retired,
    output logic [31:0]        perf_stalls
);

    seq_state_e         state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               advance;
    logic               wait_cycle;
    logic               expired;

    // All outputs are decoded from registered state so an asynchronous reset
    // clears them immediately.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        retire     = 1'b0;
        advance    = 1'b0;
        wait_cycle = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d = SEQ_RUN;
                    stage_d = STAGE_INSTR_FETCH;
                end
            end
            SEQ_RUN: begin
                case (stage_q)
                    STAGE_INSTR_FETCH: begin
                        imem_req = 1'b1;
                        // Ready wins over an expired budget in the same cycle.
                        if (imem_ready) begin
                            stage_d = STAGE_DECODE;
                            advance = 1'b1;
                        end else if (expired) begin
                            state_d = SEQ_FAULT;
                        end else begin
                            wait_cycle = 1'b1;
                        end
                    end
                    STAGE_DECODE: begin
                        stage_d = STAGE_EXECUTE;
                        advance = 1'b1;
                    end
                    STAGE_EXECUTE: begin
                        stage_d = STAGE_MEM;
                        advance = 1'b1;
                    end
                    STAGE_MEM: begin
                        if (mem_op) begin
                            dmem_req = 1'b1;
                            if (dmem_ready) begin
                                stage_d = STAGE_WRITEBACK;
                                advance = 1'b1;
                            end else if (expired) begin
                                state_d = SEQ_FAULT;
                            end else begin
                                wait_cycle = 1'b1;
                            end
                        end else begin
                            stage_d = STAGE_WRITEBACK;
                            advance = 1'b1;
                        end
                    end
                    STAGE_WRITEBACK: begin
                        retire  = 1'b1;
                        advance = 1'b1;
                        stage_d = STAGE_INSTR_FETCH;
                        if (halt_instr) begin
                            state_d = SEQ_HALTED;
                        end
                    end
                    default: begin
                        stage_d = STAGE_INSTR_FETCH;
                        advance = 1'b1;
                    end
                endcase
            end
            SEQ_HALTED: begin
                stage_d = STAGE_INSTR_FETCH;
                if (start) begin
                    state_d = SEQ_RUN;
                end
            end
            SEQ_FAULT: begin
                // Frozen until reset.
            end
            default: begin
                state_d = SEQ_IDLE;
                stage_d = STAGE_INSTR_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            stage_q <= STAGE_INSTR_FETCH;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    assign stage  = stage_q;
    assign halted = (state_q == SEQ_HALTED);
    assign fault  = (state_q == SEQ_FAULT);

    stage_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .count   (wait_cycle),
        .clear   (advance || (state_q != SEQ_RUN)),
        .expired (expired)
    );

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_retired_d = perf_retired_q;
        perf_stalls_d  = perf_stalls_q;
        if (retire) begin
            perf_retired_d = perf_retired_q + 32'd1;
        end
        if (wait_cycle) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_stalls  = perf_stalls_q;
`else
    assign perf_retired = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Directed self-checking bench for stage_sequencer, built with MAX_WAIT=4.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_ready;
    logic        mem_op;
    logic        dmem_ready;
    logic        halt_instr;
    logic [2:0]  stage;
    logic        imem_req;
    logic        dmem_req;
    logic        retire;
    logic        halted;
    logic        fault;
    logic [31:0] perf_retired;
    logic [31:0] perf_stalls;

    int total;
    int bad;

    // {retire, dmem_req, imem_req, stage}
    logic [5:0] exp_q[$];

    stage_sequencer #(
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_ready   (imem_ready),
        .mem_op       (mem_op),
        .dmem_ready   (dmem_ready),
        .halt_instr   (halt_instr),
        .stage        (stage),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .retire       (retire),
        .halted       (halted),
        .fault        (fault),
        .perf_retired (perf_retired),
        .perf_stalls  (perf_stalls)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start      = 1'b0;
        imem_ready = 1'b0;
        mem_op     = 1'b0;
        dmem_ready = 1'b0;
        halt_instr = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        total++;
        if ({stage, imem_req, dmem_req, retire, halted, fault} !== 8'b000_00000) begin
            bad++;
            $display("FAIL reset_outputs: got stage=%0d req=%b%b ret=%b halt=%b fault=%b, required all 0",
                     stage, imem_req, dmem_req, retire, halted, fault);
        end
        total++;
        if ({perf_retired, perf_stalls} !== 64'd0) begin
            bad++;
            $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_retired, perf_stalls);
        end
        // IDLE holds without start.
        tick();
        tick();
        total++;
        if ({stage, imem_req} !== 4'b000_0) begin
            bad++;
            $display("FAIL idle_hold: got stage=%0d imem_req=%b required 0/0", stage, imem_req);
        end
    endtask

    // Ready always high, no memory ops: stages 0..4 repeat, retire every 5th
    // cycle. Stray dmem_ready and a held start must have no effect.
    task automatic test_sequence();
        logic [5:0] exp;
        logic [5:0] got;
        apply_reset();
        start      = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({(i % 5) == 4, 1'b0, (i % 5) == 0, 3'(i % 5)});
        end
        for (int i = 0; i < 10; i++) begin
            exp = exp_q.pop_front();
            got = {retire, dmem_req, imem_req, stage};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL seq_cycle%0d: got ret/dreq/ireq/stage=%b required %b", i, got, exp);
            end
            tick();
        end
    endtask

    // Load with dmem_ready after 3 wait cycles: MEM spans 4 cycles, retire on
    // cycle 8, three counted stalls.
    task automatic test_load_stall();
        logic [2:0] exp_stage[8];
        logic [7:0] exp_dreq;
        logic [4:0] got;
        logic [4:0] exp;
        exp_stage = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        exp_dreq  = 8'b0111_1000;
        apply_reset();
        start      = 1'b1;
        imem_ready = 1'b1;
        mem_op     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dmem_ready = (i == 6);
            got = {retire, dmem_req, stage};
            exp = {(i == 7), exp_dreq[i], exp_stage[i]};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL load_cycle%0d: got ret/dreq/stage=%b required %b", i + 1, got, exp);
            end
            tick();
        end
        dmem_ready = 1'b0;
`ifdef SEQ_PERF_COUNTERS_EN
        total++;
        if ({perf_retired, perf_stalls} !== {32'd1, 32'd3}) begin
            bad++;
            $display("FAIL load_perf: got retired=%0d stalls=%0d required 1/3", perf_retired, perf_stalls);
        end
`endif
    endtask

    // imem_ready never comes: four counted waits, then FAULT on the 5th
    // FETCH cycle's edge. Sticky, start ignored, cleared by reset.
    task automatic test_timeout();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({fault, imem_req, stage} !== 5'b0_1_000) begin
                bad++;
                $display("FAIL timeout_wait%0d: got fault=%b ireq=%b stage=%0d required 0/1/0",
                         i, fault, imem_req, stage);
            end
            tick();
        end
        total++;
        if ({fault, imem_req, stage} !== 5'b1_0_000) begin
            bad++;
            $display("FAIL timeout_fault: got fault=%b ireq=%b stage=%0d required 1/0/0",
                     fault, imem_req, stage);
        end
        start      = 1'b1;
        imem_ready = 1'b1;
        tick();
        tick();
        start = 1'b0;
        total++;
        if ({fault, imem_req, stage} !== 5'b1_0_000) begin
            bad++;
            $display("FAIL timeout_sticky: got fault=%b ireq=%b stage=%0d required 1/0/0",
                     fault, imem_req, stage);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL timeout_reset_clear: got fault=%b required 0", fault);
        end
        tick();
        rst_n = 1'b1;
    endtask

    // Ready arrives in the cycle the counter equals MAX_WAIT: advance, no fault.
    task automatic test_ready_at_limit();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        total++;
        if ({fault, stage} !== 4'b0_001) begin
            bad++;
            $display("FAIL limit_ready: got fault=%b stage=%0d required 0/1", fault, stage);
        end
        tick();
        tick();
        tick();
        total++;
        if ({fault, stage, retire} !== 5'b0_100_1) begin
            bad++;
            $display("FAIL limit_retire: got fault=%b stage=%0d retire=%b required 0/4/1",
                     fault, stage, retire);
        end
    endtask

    // HALT at WRITEBACK parks the core; a start pulse resumes fetching.
    task automatic test_halt();
        apply_reset();
        start      = 1'b1;
        imem_ready = 1'b1;
        halt_instr = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        total++;
        if ({retire, halted, stage} !== 5'b1_0_100) begin
            bad++;
            $display("FAIL halt_wb: got retire=%b halted=%b stage=%0d required 1/0/4", retire, halted, stage);
        end
        tick();
        total++;
        if ({retire, halted, imem_req, stage} !== 6'b0_1_0_000) begin
            bad++;
            $display("FAIL halt_parked: got ret=%b halted=%b ireq=%b stage=%0d required 0/1/0/0",
                     retire, halted, imem_req, stage);
        end
        tick();
        tick();
        total++;
        if ({halted, imem_req} !== 2'b1_0) begin
            bad++;
            $display("FAIL halt_hold: got halted=%b ireq=%b required 1/0", halted, imem_req);
        end
        halt_instr = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({halted, imem_req, stage} !== 5'b0_1_000) begin
            bad++;
            $display("FAIL halt_resume: got halted=%b ireq=%b stage=%0d required 0/1/0",
                     halted, imem_req, stage);
        end
    endtask

    // Asynchronous reset mid-EXECUTE of the second instruction.
    task automatic test_async_reset();
        apply_reset();
        start      = 1'b1;
        imem_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        total++;
        if (stage !== 3'd2) begin
            bad++;
            $display("FAIL areset_pre_stage: got %0d required 2", stage);
        end
`ifdef SEQ_PERF_COUNTERS_EN
        total++;
        if (perf_retired !== 32'd1) begin
            bad++;
            $display("FAIL areset_pre_perf: got %0d required 1", perf_retired);
        end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({stage, imem_req, dmem_req, retire, halted, fault} !== 8'd0 ||
            {perf_retired, perf_stalls} !== 64'd0) begin
            bad++;
            $display("FAIL areset_immediate: got stage=%0d ireq=%b dreq=%b ret=%b halt=%b fault=%b perf=%0d/%0d required all 0",
                     stage, imem_req, dmem_req, retire, halted, fault, perf_retired, perf_stalls);
        end
        tick();
        total++;
        if ({stage, retire} !== 4'd0) begin
            bad++;
            $display("FAIL areset_held: got stage=%0d retire=%b required 0/0", stage, retire);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({stage, imem_req, retire} !== 5'd0) begin
            bad++;
            $display("FAIL areset_idle: got stage=%0d ireq=%b ret=%b required 0/0/0", stage, imem_req, retire);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_sequence();
        test_load_stall();
        test_timeout();
        test_ready_at_limit();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
